// File: rtl/hazard_ctrl_unit_pkg.sv
// rtl/hazard_ctrl_unit_pkg.sv - shared constants for the pipeline hazard control unit
package hazard_ctrl_unit_pkg;

  // Operand forwarding source selects
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EX      = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;

  // Legal multi-cycle unit occupancy and the down-counter width that covers it
  localparam int MDU_LAT_MIN = 1;
  localparam int MDU_LAT_MAX = 255;
  localparam int MDU_CNT_W   = 8;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // EX result is younger than MEM, so it wins when both match
  function automatic logic [1:0] fwd_pick(input logic ex_dep, input logic mem_dep);
    if (ex_dep)       return FWD_EX;
    else if (mem_dep) return FWD_MEM;
    else              return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_cmp.sv
// rtl/hazard_ctrl_unit_cmp.sv - EX/MEM dependency detection for one source operand
module hazard_cmp #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  valid,
  input  logic                  use_src,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] ex_wreg,
  input  logic                  ex_we,
  input  logic [REG_ADDR_W-1:0] mem_wreg,
  input  logic                  mem_we,
  output logic                  ex_dep,
  output logic                  mem_dep
);

  logic src_live;

  // Register 0 is hardwired, so it never carries a dependency
  assign src_live = valid && use_src && (src != '0);
  assign ex_dep   = src_live && ex_we  && (src == ex_wreg);
  assign mem_dep  = src_live && mem_we && (src == mem_wreg);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - forwarding, stall, flush and MDU occupancy control for the pipeline
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_EN      = 1,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_is_mdu,
  input  logic [REG_ADDR_W-1:0] ex_wreg,
  input  logic                  ex_we,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] mem_wreg,
  input  logic                  mem_we,
  input  logic                  branch_taken,
  output logic [1:0]            fwd_rs_sel,
  output logic [1:0]            fwd_rt_sel,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  mdu_busy,
  output logic [CNT_W-1:0]      stall_count
);

  logic rs_ex_dep, rs_mem_dep, rt_ex_dep, rt_mem_dep;

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs (
    .valid    (id_valid),
    .use_src  (id_use_rs),
    .src      (id_rs),
    .ex_wreg  (ex_wreg),
    .ex_we    (ex_we),
    .mem_wreg (mem_wreg),
    .mem_we   (mem_we),
    .ex_dep   (rs_ex_dep),
    .mem_dep  (rs_mem_dep)
  );

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rt (
    .valid    (id_valid),
    .use_src  (id_use_rt),
    .src      (id_rt),
    .ex_wreg  (ex_wreg),
    .ex_we    (ex_we),
    .mem_wreg (mem_wreg),
    .mem_we   (mem_we),
    .ex_dep   (rt_ex_dep),
    .mem_dep  (rt_mem_dep)
  );

  state_t                 state, state_nx;
  logic [MDU_CNT_W-1:0]   mdu_cnt, mdu_cnt_nx;
  logic                   load_use, dep_stall, mdu_stall, hazard_stall, mdu_accept;

  always_comb begin
    load_use  = 1'b0;
    dep_stall = 1'b0;
    if (FWD_EN != 0) begin
      load_use = ex_is_load && (rs_ex_dep || rt_ex_dep);
    end else begin
      dep_stall = rs_ex_dep || rs_mem_dep || rt_ex_dep || rt_mem_dep;
    end
    mdu_stall    = (state == MDU_WAIT) && id_valid && id_is_mdu;
    hazard_stall = load_use || dep_stall || mdu_stall;
    mdu_accept   = (state == RUN) && id_valid && id_is_mdu && !hazard_stall && !branch_taken;
  end

  // Reset and branch redirect both override every stall source
  always_comb begin
    fwd_rs_sel = FWD_REGFILE;
    fwd_rt_sel = FWD_REGFILE;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    if (rst) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else begin
      if (FWD_EN != 0) begin
        fwd_rs_sel = fwd_pick(rs_ex_dep, rs_mem_dep);
        fwd_rt_sel = fwd_pick(rt_ex_dep, rt_mem_dep);
      end
      if (branch_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else begin
        stall_if = hazard_stall;
        stall_id = hazard_stall;
        flush_ex = load_use;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    mdu_cnt_nx = mdu_cnt;
    case (state)
      RUN: begin
        if (mdu_accept && (MDU_LATENCY > 1)) begin
          state_nx   = MDU_WAIT;
          mdu_cnt_nx = MDU_CNT_W'(MDU_LATENCY - 1);
        end
      end
      MDU_WAIT: begin
        mdu_cnt_nx = mdu_cnt - MDU_CNT_W'(1);
        if (mdu_cnt == MDU_CNT_W'(1)) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      mdu_cnt     <= '0;
      stall_count <= '0;
    end else begin
      state   <= state_nx;
      mdu_cnt <= mdu_cnt_nx;
      if (stall_id && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign mdu_busy = (state == MDU_WAIT);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  localparam int AW = 5;
  localparam int CW = 16;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, id_use_rs, id_use_rt, id_is_mdu;
  logic ex_we, ex_is_load, mem_we, branch_taken;
  logic [AW-1:0] id_rs, id_rt, ex_wreg, mem_wreg;

  logic [1:0] a_fwd_rs_sel, a_fwd_rt_sel, b_fwd_rs_sel, b_fwd_rt_sel;
  logic a_stall_if, a_stall_id, a_flush_id, a_flush_ex, a_mdu_busy;
  logic b_stall_if, b_stall_id, b_flush_id, b_flush_ex, b_mdu_busy;
  logic [CW-1:0] a_stall_count, b_stall_count;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0] rs;
    logic [1:0] rt;
    logic sif, sid, fid, fex, acc;
  } exp_t;

  int ma_left, mb_left, ma_cnt, mb_cnt;

  hazard_ctrl_unit #(.REG_ADDR_W(AW), .FWD_EN(1), .MDU_LATENCY(LAT_A), .CNT_W(CW)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_mdu(id_is_mdu),
    .ex_wreg(ex_wreg), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_wreg(mem_wreg), .mem_we(mem_we), .branch_taken(branch_taken),
    .fwd_rs_sel(a_fwd_rs_sel), .fwd_rt_sel(a_fwd_rt_sel),
    .stall_if(a_stall_if), .stall_id(a_stall_id), .flush_id(a_flush_id), .flush_ex(a_flush_ex),
    .mdu_busy(a_mdu_busy), .stall_count(a_stall_count)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(AW), .FWD_EN(0), .MDU_LATENCY(LAT_B), .CNT_W(CW)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_mdu(id_is_mdu),
    .ex_wreg(ex_wreg), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_wreg(mem_wreg), .mem_we(mem_we), .branch_taken(branch_taken),
    .fwd_rs_sel(b_fwd_rs_sel), .fwd_rt_sel(b_fwd_rt_sel),
    .stall_if(b_stall_if), .stall_id(b_stall_id), .flush_id(b_flush_id), .flush_ex(b_flush_ex),
    .mdu_busy(b_mdu_busy), .stall_count(b_stall_count)
  );

  function automatic bit dep(input logic u, input logic [AW-1:0] s, input logic [AW-1:0] w, input logic we);
    return id_valid && u && we && (s == w) && (s != 0);
  endfunction

  function automatic exp_t model(input bit fwd_en, input int left);
    exp_t e;
    bit rs_ex, rs_mem, rt_ex, rt_mem, lu, nf, mw, st;
    rs_ex  = dep(id_use_rs, id_rs, ex_wreg, ex_we);
    rs_mem = dep(id_use_rs, id_rs, mem_wreg, mem_we);
    rt_ex  = dep(id_use_rt, id_rt, ex_wreg, ex_we);
    rt_mem = dep(id_use_rt, id_rt, mem_wreg, mem_we);
    e.rs = 2'd0;
    e.rt = 2'd0;
    if (fwd_en) begin
      e.rs = rs_ex ? 2'd1 : (rs_mem ? 2'd2 : 2'd0);
      e.rt = rt_ex ? 2'd1 : (rt_mem ? 2'd2 : 2'd0);
    end
    lu = fwd_en && ex_is_load && (rs_ex || rt_ex);
    nf = !fwd_en && (rs_ex || rs_mem || rt_ex || rt_mem);
    mw = (left > 0) && id_valid && id_is_mdu;
    st = lu || nf || mw;
    if (rst) begin
      e.rs = 2'd0; e.rt = 2'd0;
      e.sif = 0; e.sid = 0; e.fid = 1; e.fex = 1;
    end else if (branch_taken) begin
      e.sif = 0; e.sid = 0; e.fid = 1; e.fex = 1;
    end else begin
      e.sif = st; e.sid = st; e.fid = 0; e.fex = lu;
    end
    e.acc = !rst && (left == 0) && id_valid && id_is_mdu && !branch_taken && !st;
    return e;
  endfunction

  function automatic int next_left(input int left, input bit acc, input int lat);
    if (rst) return 0;
    if (left > 0) return left - 1;
    if (acc) return lat - 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_is_mdu = 0;
    id_rs = '0; id_rt = '0; ex_wreg = '0; ex_we = 0; ex_is_load = 0;
    mem_wreg = '0; mem_we = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    rst = 0;
  endtask

  task automatic set_load_use();
    idle();
    id_valid = 1; id_use_rt = 1; id_rt = 5'd5; ex_wreg = 5'd5; ex_we = 1; ex_is_load = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    id_valid = 1; id_use_rs = 1; id_rs = 5'd3; ex_wreg = 5'd3; ex_we = 1; ex_is_load = 1; branch_taken = 0;
    #2;
    total++;
    if ({a_flush_id, a_flush_ex, a_stall_if, a_stall_id, a_fwd_rs_sel, a_fwd_rt_sel} !== 8'b1100_0000) begin
      bad++; $display("FAIL reset_out_a got=%b exp=11000000", {a_flush_id, a_flush_ex, a_stall_if, a_stall_id, a_fwd_rs_sel, a_fwd_rt_sel});
    end
    total++;
    if ({b_flush_id, b_flush_ex, b_stall_if, b_stall_id, b_fwd_rs_sel, b_fwd_rt_sel} !== 8'b1100_0000) begin
      bad++; $display("FAIL reset_out_b got=%b exp=11000000", {b_flush_id, b_flush_ex, b_stall_if, b_stall_id, b_fwd_rs_sel, b_fwd_rt_sel});
    end
    tick();
    total++;
    if (a_mdu_busy !== 1'b0 || a_stall_count !== 16'd0) begin
      bad++; $display("FAIL reset_state busy=%b count=%0d exp busy=0 count=0", a_mdu_busy, a_stall_count);
    end
    rst = 0;
    idle();
  endtask

  task automatic test_ex_forward();
    idle();
    id_valid = 1; id_use_rs = 1; id_rs = 5'd3; ex_wreg = 5'd3; ex_we = 1;
    #2;
    total++;
    if (a_fwd_rs_sel !== 2'd1 || a_stall_id !== 1'b0) begin
      bad++; $display("FAIL ex_fwd sel=%0d stall=%b exp sel=1 stall=0", a_fwd_rs_sel, a_stall_id);
    end
    mem_wreg = 5'd3; mem_we = 1;
    #1;
    total++;
    if (a_fwd_rs_sel !== 2'd1) begin
      bad++; $display("FAIL ex_priority sel=%0d exp=1", a_fwd_rs_sel);
    end
    ex_we = 0;
    #1;
    total++;
    if (a_fwd_rs_sel !== 2'd2 || a_stall_id !== 1'b0) begin
      bad++; $display("FAIL mem_fwd sel=%0d stall=%b exp sel=2 stall=0", a_fwd_rs_sel, a_stall_id);
    end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #2;
    total++;
    if ({a_stall_if, a_stall_id, a_flush_ex, a_flush_id} !== 4'b1110 || a_stall_count !== 16'd0) begin
      bad++; $display("FAIL load_use sif/sid/fex/fid=%b count=%0d exp 1110 count=0",
                      {a_stall_if, a_stall_id, a_flush_ex, a_flush_id}, a_stall_count);
    end
    tick();
    total++;
    if (a_stall_count !== 16'd1) begin
      bad++; $display("FAIL load_use_count got=%0d exp=1", a_stall_count);
    end
    ex_we = 0; ex_is_load = 0; mem_wreg = 5'd5; mem_we = 1;
    #2;
    total++;
    if (a_fwd_rt_sel !== 2'd2 || a_stall_id !== 1'b0) begin
      bad++; $display("FAIL load_then_mem sel=%0d stall=%b exp sel=2 stall=0", a_fwd_rt_sel, a_stall_id);
    end
    tick();
    idle();
  endtask

  task automatic test_reg_zero_nofwd();
    idle();
    id_valid = 1; id_use_rs = 1; id_rs = '0; ex_wreg = '0; ex_we = 1;
    #2;
    total++;
    if (a_fwd_rs_sel !== 2'd0 || a_stall_id !== 1'b0 || b_stall_id !== 1'b0) begin
      bad++; $display("FAIL reg_zero sel=%0d stall_a=%b stall_b=%b exp 0/0/0", a_fwd_rs_sel, a_stall_id, b_stall_id);
    end
    ex_we = 0; id_rs = 5'd7; mem_wreg = 5'd7; mem_we = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (b_stall_id !== 1'b1 || b_stall_if !== 1'b1 || b_fwd_rs_sel !== 2'd0) begin
        bad++; $display("FAIL nofwd_stall cyc=%0d sid=%b sif=%b sel=%0d exp 1/1/0", c, b_stall_id, b_stall_if, b_fwd_rs_sel);
      end
      tick();
    end
    mem_we = 0;
    #2;
    total++;
    if (b_stall_id !== 1'b0) begin
      bad++; $display("FAIL nofwd_release sid=%b exp=0", b_stall_id);
    end
    tick();
    idle();
  endtask

  task automatic test_mdu();
    logic [1:0] exp_sb [0:5];
    exp_sb[0] = 2'b00; exp_sb[1] = 2'b01; exp_sb[2] = 2'b11;
    exp_sb[3] = 2'b11; exp_sb[4] = 2'b00; exp_sb[5] = 2'b01;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0 || c >= 2) begin
        id_valid = (c <= 4); id_is_mdu = (c <= 4);
      end
      #2;
      total++;
      if ({a_stall_id, a_mdu_busy} !== exp_sb[c]) begin
        bad++; $display("FAIL mdu_seq t+%0d stall/busy=%b exp=%b", c, {a_stall_id, a_mdu_busy}, exp_sb[c]);
      end
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_branch();
    do_reset();
    set_load_use();
    branch_taken = 1;
    #2;
    total++;
    if ({a_flush_id, a_flush_ex, a_stall_id, a_stall_if} !== 4'b1100) begin
      bad++; $display("FAIL branch_over_load fid/fex/sid/sif=%b exp=1100", {a_flush_id, a_flush_ex, a_stall_id, a_stall_if});
    end
    tick();
    total++;
    if (a_stall_count !== 16'd0) begin
      bad++; $display("FAIL branch_count got=%0d exp=0", a_stall_count);
    end
    idle();
    id_valid = 1; id_is_mdu = 1;
    tick();
    id_valid = 1; id_is_mdu = 1; branch_taken = 1;
    #2;
    total++;
    if (a_mdu_busy !== 1'b1 || a_stall_id !== 1'b0 || a_flush_id !== 1'b1) begin
      bad++; $display("FAIL branch_in_mdu busy=%b sid=%b fid=%b exp 1/0/1", a_mdu_busy, a_stall_id, a_flush_id);
    end
    tick();
    idle();
    tick();
    tick();
    total++;
    if (a_mdu_busy !== 1'b0) begin
      bad++; $display("FAIL mdu_survives_branch busy=%b exp=0 at t+4", a_mdu_busy);
    end
    id_valid = 1; id_is_mdu = 1; branch_taken = 1;
    tick();
    idle();
    #1;
    total++;
    if (a_mdu_busy !== 1'b0) begin
      bad++; $display("FAIL mdu_blocked_by_branch busy=%b exp=0", a_mdu_busy);
    end
    tick();
  endtask

  task automatic test_reset_mdu();
    set_load_use();
    tick();
    idle();
    id_valid = 1; id_is_mdu = 1;
    tick();
    rst = 1;
    idle();
    tick();
    rst = 0;
    #1;
    total++;
    if (a_mdu_busy !== 1'b0 || a_stall_count !== 16'd0) begin
      bad++; $display("FAIL reset_mid_mdu busy=%b count=%0d exp 0/0", a_mdu_busy, a_stall_count);
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    set_load_use();
    repeat (70000) @(posedge clk);
    #1;
    total++;
    if (a_stall_count !== 16'hFFFF || a_stall_id !== 1'b1) begin
      bad++; $display("FAIL saturate count=%0d sid=%b exp 65535/1", a_stall_count, a_stall_id);
    end
    tick();
    total++;
    if (a_stall_count !== 16'hFFFF) begin
      bad++; $display("FAIL saturate_hold count=%0d exp=65535", a_stall_count);
    end
    idle();
  endtask

  task automatic test_random();
    exp_t ea, eb;
    logic [8:0] ga, gb, xa, xb;
    do_reset();
    ma_left = 0; mb_left = 0; ma_cnt = 0; mb_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_use_rs    = 1'($urandom);
      id_use_rt    = 1'($urandom);
      id_is_mdu    = ($urandom_range(0, 2) == 0);
      id_rs        = AW'($urandom_range(0, 3));
      id_rt        = AW'($urandom_range(0, 3));
      ex_wreg      = AW'($urandom_range(0, 3));
      mem_wreg     = AW'($urandom_range(0, 3));
      ex_we        = 1'($urandom);
      ex_is_load   = 1'($urandom);
      mem_we       = 1'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      #2;
      ea = model(1'b1, ma_left);
      eb = model(1'b0, mb_left);
      ga = {a_fwd_rs_sel, a_fwd_rt_sel, a_stall_if, a_stall_id, a_flush_id, a_flush_ex, a_mdu_busy};
      xa = {ea.rs, ea.rt, ea.sif, ea.sid, ea.fid, ea.fex, 1'(ma_left > 0)};
      gb = {b_fwd_rs_sel, b_fwd_rt_sel, b_stall_if, b_stall_id, b_flush_id, b_flush_ex, b_mdu_busy};
      xb = {eb.rs, eb.rt, eb.sif, eb.sid, eb.fid, eb.fex, 1'(mb_left > 0)};
      total++;
      if (ga !== xa) begin
        bad++; $display("FAIL rand_out_a cyc=%0d got=%b exp=%b", i, ga, xa);
      end
      total++;
      if (gb !== xb) begin
        bad++; $display("FAIL rand_out_b cyc=%0d got=%b exp=%b", i, gb, xb);
      end
      total++;
      if (a_stall_count !== CW'(ma_cnt) || b_stall_count !== CW'(mb_cnt)) begin
        bad++; $display("FAIL rand_count cyc=%0d got=%0d/%0d exp=%0d/%0d", i, a_stall_count, b_stall_count, ma_cnt, mb_cnt);
      end
      ma_left = next_left(ma_left, ea.acc, LAT_A);
      mb_left = next_left(mb_left, eb.acc, LAT_B);
      if (rst) begin
        ma_cnt = 0; mb_cnt = 0;
      end else begin
        if (ea.sid && ma_cnt < 65535) ma_cnt++;
        if (eb.sid && mb_cnt < 65535) mb_cnt++;
      end
      tick();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    tick();
    test_reset();
    test_ex_forward();
    test_load_use();
    test_reg_zero_nofwd();
    test_mdu();
    test_branch();
    test_reset_mdu();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
